// File: rtl/pipelined_memory_stage.sv
// pipelined_memory_stage: MEM stage with load/store/push/pop, internal stack pointer and wait-state stalls
module pipelined_memory_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_BITS   = 10,
  parameter int CTRL_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] StoreData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  Push,
  input  logic                  Pop,
  input  logic [CTRL_WIDTH-1:0] CtrlIn,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] MemDataOut,
  output logic [DATA_WIDTH-1:0] ALUResultOut,
  output logic [CTRL_WIDTH-1:0] CtrlOut,
  output logic                  Fault,
  output logic [ADDR_BITS-1:0]  SP
);
  typedef enum logic [1:0] {IDLE, ACCESS, FULL} state_e;
  typedef enum logic [2:0] {OP_NONE, OP_LOAD, OP_STORE, OP_PUSH, OP_POP} op_e;
  localparam bit W0 = WAIT_STATES == 0;
  state_e                state_q, state_d;
  op_e                   op_q, op_d, in_op, ex_op;
  logic [3:0]            cnt_q, cnt_d, sel;
  logic [ADDR_BITS-1:0]  addr_q, addr_d, sp_q, sp_d, ex_addr, mem_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, ex_data, rdata, mdo_q, mdo_d, alu_q, alu_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                  fault_q, fault_d, in_fault, illegal, oor, accept, do_exec, we;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_comb begin
    sel      = {MemRead, MemWrite, Push, Pop};
    illegal  = (sel & (sel - 4'd1)) != 4'd0;
    oor      = (MemRead || MemWrite) && ((ALUResult >> ADDR_BITS) != '0);
    in_fault = illegal || oor;
    in_op    = in_fault ? OP_NONE : MemRead ? OP_LOAD : MemWrite ? OP_STORE :
               Push ? OP_PUSH : Pop ? OP_POP : OP_NONE;
    InReady  = state_q == IDLE || (state_q == FULL && OutReady);
    accept   = InValid && InReady;
    // With wait states the op is replayed from the latched copy on its last ACCESS cycle
    ex_op    = state_q == ACCESS ? op_q : in_op;
    ex_addr  = state_q == ACCESS ? addr_q : ALUResult[ADDR_BITS-1:0];
    ex_data  = state_q == ACCESS ? wdata_q : StoreData;
    do_exec  = (state_q == ACCESS && cnt_q == '0) || (W0 && accept && in_op != OP_NONE);
    mem_addr = ex_op == OP_PUSH ? sp_q : ex_op == OP_POP ? sp_q + 1'b1 : ex_addr;
    we       = do_exec && (ex_op == OP_STORE || ex_op == OP_PUSH);
    rdata    = mem[mem_addr];
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    alu_d    = alu_q;
    ctrl_d   = ctrl_q;
    fault_d  = fault_q;
    mdo_d    = mdo_q;
    sp_d     = sp_q;
    cnt_d    = (state_q == ACCESS && cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
    if (accept) begin
      op_d    = in_op;
      addr_d  = ALUResult[ADDR_BITS-1:0];
      wdata_d = StoreData;
      alu_d   = ALUResult;
      ctrl_d  = CtrlIn;
      fault_d = in_fault;
      mdo_d   = '0;
      cnt_d   = 4'(WAIT_STATES - 1);
    end
    if (do_exec) begin
      mdo_d = (ex_op == OP_LOAD || ex_op == OP_POP) ? rdata : '0;
      sp_d  = ex_op == OP_PUSH ? sp_q - 1'b1 : ex_op == OP_POP ? sp_q + 1'b1 : sp_q;
    end
    state_d = state_q == ACCESS ? (cnt_q == '0 ? FULL : ACCESS) :
              accept ? ((in_op != OP_NONE && !W0) ? ACCESS : FULL) :
              (state_q == FULL && OutReady) ? IDLE : state_q;
    OutValid     = state_q == FULL;
    MemDataOut   = mdo_q;
    ALUResultOut = alu_q;
    CtrlOut      = ctrl_q;
    Fault        = fault_q;
    SP           = sp_q;
  end

  always_ff @(posedge clk)
    if (we && !rst) mem[mem_addr] <= ex_data;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      alu_q   <= '0;
      ctrl_q  <= '0;
      fault_q <= 1'b0;
      mdo_q   <= '0;
      sp_q    <= '1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      alu_q   <= alu_d;
      ctrl_q  <= ctrl_d;
      fault_q <= fault_d;
      mdo_q   <= mdo_d;
      sp_q    <= sp_d;
    end
endmodule

// File: tb/tb_pipelined_memory_stage.sv
// tb_pipelined_memory_stage: directed stimulus with a queued scoreboard checked by an output monitor
module tb_pipelined_memory_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        InValid = 1'b0, InReady, OutValid, OutReady = 1'b0, Fault;
  logic [15:0] ALUResult = '0, StoreData = '0, MemDataOut, ALUResultOut;
  logic        MemRead = 1'b0, MemWrite = 1'b0, Push = 1'b0, Pop = 1'b0;
  logic [9:0]  CtrlIn = '0, CtrlOut, SP;

  typedef struct {
    logic [15:0] mdo;
    logic [15:0] alu;
    logic [9:0]  ctrl;
    logic        f;
    logic [9:0]  sp;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;

  pipelined_memory_stage dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
    .ALUResult(ALUResult), .StoreData(StoreData), .MemRead(MemRead), .MemWrite(MemWrite),
    .Push(Push), .Pop(Pop), .CtrlIn(CtrlIn), .OutValid(OutValid), .OutReady(OutReady),
    .MemDataOut(MemDataOut), .ALUResultOut(ALUResultOut), .CtrlOut(CtrlOut),
    .Fault(Fault), .SP(SP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst && OutValid && OutReady) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got alu=%h with nothing expected", ALUResultOut);
      end else begin
        e = q.pop_front();
        chk("mem_data", 32'(MemDataOut), 32'(e.mdo));
        chk("alu_out", 32'(ALUResultOut), 32'(e.alu));
        chk("ctrl_out", 32'(CtrlOut), 32'(e.ctrl));
        chk("fault", 32'(Fault), 32'(e.f));
        chk("sp", 32'(SP), 32'(e.sp));
      end
    end

  // Called at posedge+1; returns at posedge+1 right after the DUT accepted the op
  task automatic issue(input logic [3:0] s, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [9:0] ctrl, input logic [15:0] emdo, input logic ef,
                       input logic [9:0] esp);
    int k;
    q.push_back('{emdo, alu, ctrl, ef, esp});
    {MemRead, MemWrite, Push, Pop} = s;
    ALUResult = alu;
    StoreData = sd;
    CtrlIn = ctrl;
    InValid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!InReady && k < 100);
    if (!InReady) chk("issue_timeout", 32'(InReady), 32'd1);
    @(posedge clk);
    #1;
    InValid = 1'b0;
    {MemRead, MemWrite, Push, Pop} = 4'b0;
  endtask

  task automatic issue_lat(input logic [3:0] s, input logic [15:0] alu, input logic [15:0] sd,
                           input logic [9:0] ctrl, input logic [15:0] emdo, input logic ef,
                           input logic [9:0] esp, input int elat);
    int lat;
    issue(s, alu, sd, ctrl, emdo, ef, esp);
    lat = 1;
    @(negedge clk);
    if (elat > 1) chk("inready_in_access", 32'(InReady), 32'd0);
    while (!OutValid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_sp", 32'(SP), 32'h3FF);
    chk("rst_inready", 32'(InReady), 32'd1);
    chk("rst_mdo", 32'(MemDataOut), 32'd0);
    chk("rst_alu", 32'(ALUResultOut), 32'd0);
    chk("rst_ctrl", 32'(CtrlOut), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    @(posedge clk);
    #1 OutReady = 1'b1;
    // store/load round trip with wait states
    issue_lat(4'b0100, 16'h0005, 16'hBEEF, 10'h001, 16'h0000, 1'b0, 10'h3FF, 3);
    issue_lat(4'b1000, 16'h0005, 16'h0000, 10'h002, 16'hBEEF, 1'b0, 10'h3FF, 3);
    // stack push/pop ordering
    issue_lat(4'b0010, 16'h0000, 16'h1111, 10'h003, 16'h0000, 1'b0, 10'h3FE, 3);
    issue_lat(4'b0010, 16'h0000, 16'h2222, 10'h004, 16'h0000, 1'b0, 10'h3FD, 3);
    issue_lat(4'b0001, 16'h0000, 16'h0000, 10'h005, 16'h2222, 1'b0, 10'h3FE, 3);
    issue_lat(4'b0001, 16'h0000, 16'h0000, 10'h006, 16'h1111, 1'b0, 10'h3FF, 3);
    // stack pointer wrap in both directions
    issue_lat(4'b0100, 16'h0000, 16'h0AAA, 10'h007, 16'h0000, 1'b0, 10'h3FF, 3);
    issue_lat(4'b0001, 16'h0000, 16'h0000, 10'h008, 16'h0AAA, 1'b0, 10'h000, 3);
    issue_lat(4'b0010, 16'h0000, 16'h5555, 10'h009, 16'h0000, 1'b0, 10'h3FF, 3);
    issue_lat(4'b1000, 16'h0000, 16'h0000, 10'h00A, 16'h5555, 1'b0, 10'h3FF, 3);
    // illegal ops and out-of-range addresses
    issue_lat(4'b1100, 16'h0000, 16'hDEAD, 10'h00B, 16'h0000, 1'b1, 10'h3FF, 1);
    issue_lat(4'b1000, 16'h0000, 16'h0000, 10'h00C, 16'h5555, 1'b0, 10'h3FF, 3);
    issue_lat(4'b0011, 16'h0000, 16'hABCD, 10'h00D, 16'h0000, 1'b1, 10'h3FF, 1);
    issue_lat(4'b1000, 16'h0400, 16'h0000, 10'h00E, 16'h0000, 1'b1, 10'h3FF, 1);
    issue_lat(4'b0100, 16'h8005, 16'h1234, 10'h00F, 16'h0000, 1'b1, 10'h3FF, 1);
    issue_lat(4'b1000, 16'h0005, 16'h0000, 10'h010, 16'hBEEF, 1'b0, 10'h3FF, 3);
    // backpressure with three none-class ops
    OutReady = 1'b0;
    fork
      begin
        issue(4'b0000, 16'h0A01, 16'h0000, 10'h011, 16'h0000, 1'b0, 10'h3FF);
        issue(4'b0000, 16'h0A02, 16'h0000, 10'h012, 16'h0000, 1'b0, 10'h3FF);
        issue(4'b0000, 16'h0A03, 16'h0000, 10'h013, 16'h0000, 1'b0, 10'h3FF);
      end
    join_none
    @(posedge clk);
    #1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_outvalid", 32'(OutValid), 32'd1);
      chk("bp_held_alu", 32'(ALUResultOut), 32'h0A01);
      chk("bp_inready", 32'(InReady), 32'd0);
    end
    @(posedge clk);
    #1 OutReady = 1'b1;
    @(negedge clk);
    chk("bp_adv0", 32'(ALUResultOut), 32'h0A01);
    @(negedge clk);
    chk("bp_adv1", 32'(ALUResultOut), 32'h0A02);
    @(negedge clk);
    chk("bp_adv2", 32'(ALUResultOut), 32'h0A03);
    wait fork;
    @(posedge clk);
    #1;
    // reset two cycles into a push must discard it
    issue_lat(4'b0100, 16'h03FF, 16'h7777, 10'h014, 16'h0000, 1'b0, 10'h3FF, 3);
    Push = 1'b1;
    StoreData = 16'h9999;
    InValid = 1'b1;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    Push = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outvalid", 32'(OutValid), 32'd0);
    chk("rst_mid_sp", 32'(SP), 32'h3FF);
    @(posedge clk);
    #1 rst = 1'b0;
    issue_lat(4'b1000, 16'h03FF, 16'h0000, 10'h015, 16'h7777, 1'b0, 10'h3FF, 3);
    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_memory_stage.md
# pipelined_memory_stage

Parametrised MEM stage of the RISC pipeline: takes one instruction's ALU result, store data and control bits from EX/MEM, performs a data-memory load, store, PUSH or POP, and presents the result to MEM/WB with a valid/ready handshake. It owns the stack pointer as an internal register with wrap-around, and models configurable memory wait states by stalling upstream. Memory width, depth, control width and latency are parameters.

## Interface
- DATA_WIDTH, 16, data word and ALU result width
- ADDR_BITS, 10, memory address width; depth = 2^ADDR_BITS words
- CTRL_WIDTH, 10, write-back control bits carried through untouched (Rdst, Rsrc, WB enables)
- WAIT_STATES, 2, extra cycles per memory access (0..15)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- InValid  in  1  EX/MEM holds a valid instruction
- InReady  out  1  stage accepts the instruction this cycle
- ALUResult  in  DATA_WIDTH  effective address for load/store; pass-through value
- StoreData  in  DATA_WIDTH  data for store/PUSH
- MemRead, MemWrite, Push, Pop  in  1 each  operation select
- CtrlIn  in  CTRL_WIDTH  pass-through control
- OutValid  out  1  MEM/WB output valid
- OutReady  in  1  MEM/WB consumes output this cycle
- MemDataOut  out  DATA_WIDTH  load/POP data; 0 otherwise
- ALUResultOut  out  DATA_WIDTH  registered ALUResult
- CtrlOut  out  CTRL_WIDTH  registered CtrlIn
- Fault  out  1  qualifies current output: illegal op or out-of-range address
- SP  out  ADDR_BITS  current stack pointer (debug/visibility)

## Operation
- Transfer in: InValid & InReady. Transfer out: OutValid & OutReady.
- FSM states: IDLE (output empty), ACCESS (memory op in flight, counter running), FULL (output valid).
- InReady = (state==IDLE) | (state==FULL & OutReady). Never high in ACCESS.
- Accepted op classes: none (no select bit), LOAD (MemRead), STORE (MemWrite), PUSH, POP. More than one select bit -> illegal: no memory/SP change, Fault=1, handled as none.
- Address: LOAD/STORE use ALUResult; if ALUResult >= 2^ADDR_BITS, access suppressed, MemDataOut=0, Fault=1, handled as none.
- PUSH: Mem[SP] <= StoreData, then SP <= SP-1. POP: SP <= SP+1, MemDataOut <= Mem[SP+1]. Arithmetic modulo 2^ADDR_BITS (wraps silently, no Fault).
- Memory write and SP update both occur on the final ACCESS cycle; read data is sampled from the memory on that same cycle (post-SP-address for POP).
- Ops of class none: IDLE/FULL -> FULL directly, no ACCESS.
- Memory ops with WAIT_STATES=0 also bypass ACCESS: single-cycle, same as none.
- Transitions: IDLE -accept none-> FULL; IDLE -accept mem-> ACCESS; ACCESS -counter==0-> FULL; FULL -out only-> IDLE; FULL -out & accept-> FULL or ACCESS; FULL -no out-> FULL (outputs held stable).
- Memory contents are not reset; undefined until written.

## Timing
- Reset values: OutValid=0, MemDataOut=0, ALUResultOut=0, CtrlOut=0, Fault=0, SP=2^ADDR_BITS-1, state IDLE, InReady=1 after reset deasserts.
- Reset mid-ACCESS: op discarded, no memory write, SP restored to reset value.
- Latency accept->OutValid: 1 cycle for none/illegal/fault/WAIT_STATES=0; 1+WAIT_STATES cycles for memory ops.
- Throughput: 1 op/cycle for none-class ops with OutReady held high; memory ops 1 per 1+WAIT_STATES cycles.
- Back-to-back PUSH then POP sees the pushed value (SP update committed before the POP's access).
- Output registers change only on transfer-in completion; held while OutValid & !OutReady.

## Test plan
- Reset, WAIT_STATES=2: OutValid=0, SP=0x3FF, InReady=1; STORE 0xBEEF to addr 5 then LOAD addr 5 -> MemDataOut=0xBEEF, each OutValid 3 cycles after accept, InReady low during ACCESS.
- PUSH 0x1111, PUSH 0x2222, POP, POP -> SP 0x3FF->0x3FE->0x3FD->0x3FE->0x3FF; POP data 0x2222 then 0x1111.
- Wrap: from reset, POP -> SP=0x000, reads Mem[0]; PUSH at SP=0 -> SP=0x3FF, Fault=0.
- Backpressure: OutReady=0 with three none-class ops queued -> first output held constant, InReady=0 until OutReady rises, then outputs advance one per cycle.
- Faults: MemRead&MemWrite -> Fault=1, memory and SP unchanged; LOAD addr 0x0400 -> Fault=1, MemDataOut=0, 1-cycle latency.
- Assert rst two cycles into a PUSH -> no write at Mem[SP], SP=0x3FF, OutValid=0.
